// File: rtl/wb_keypad.sv
// rtl/wb_keypad.sv - Wishbone 4x4 matrix keypad scanner with debounce and key FIFO
//
// Purpose:
//   Drives one keypad column low at a time and samples the four rows. A press
//   seen at the end of a column slot is debounced. A stable press pushes one
//   key code (row*4 + col) into a small FIFO, and the CPU reads that FIFO over
//   Wishbone. The key must then be fully released, and stay released, before
//   scanning resumes, so a held key never auto-repeats.
//
// Ports:
//   i_wb_clk, i_wb_rst_n      clock, asynchronous active-low reset
//   i_wb_adr                  register select: 0 = DATA, 1 = STATUS
//   i_wb_dat, i_wb_sel        write data, byte selects (only sel[0] is used)
//   i_wb_we, i_wb_cyc, i_wb_stb  Wishbone request
//   o_wb_rdt, o_wb_ack        registered read data, single-cycle acknowledge
//   o_irq                     interrupt (present only with KEYPAD_IRQ_EN)
//   o_col                     column drives, active-low, one-hot-low
//   i_row                     row inputs, active-low, asynchronous
//
// Registers:
//   DATA   read : bit8 = valid, bits[3:0] = head key code; the read pops
//   STATUS read : bits[8+FIFO_AW:8] = count, bit1 = IE, bit0 = overflow
//   STATUS write: bit0 = 1 clears overflow, bit1 = IE, bit2 = 1 flushes FIFO
//
// Optional feature macro: KEYPAD_IRQ_EN (adds o_irq and a stored IE bit).

module wb_keypad #(
  parameter logic [31:0] SCAN_CNT = 32'd50000,
  parameter logic [31:0] DEB_CNT  = 32'd500000,
  parameter int          FIFO_AW  = 2
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
`ifdef KEYPAD_IRQ_EN
  output logic        o_irq,
`endif
  output logic [3:0]  o_col,
  input  logic [3:0]  i_row
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Row synchronizer. The keypad rows are asynchronous. Both flops reset to
  // "idle" so that reset cannot produce a phantom press.
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta_q;
  logic [3:0] row_sync_q;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= i_row;
      row_sync_q <= row_meta_q;
    end
  end

  logic       any_row;
  logic [1:0] low_row;

  assign any_row = (row_sync_q != 4'hF);

  // Lowest-index active row wins when several keys share the column.
  always_comb begin
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) low_row = 2'(r);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_q, row_d;
  logic [31:0] cnt_q, cnt_d;
  logic        key_push;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= SCAN_CNT - 32'd1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    key_push = 1'b0;
    case (state_q)
      ST_SCAN: begin
        // The decision is made on the last cycle of the slot. By then the
        // synchronizer holds rows sampled with this column driven.
        if (cnt_q == 32'd0) begin
          if (any_row) begin
            state_d = ST_DEBOUNCE;
            row_d   = low_row;
            cnt_d   = DEB_CNT - 32'd1;
          end else begin
            col_d = col_q + 2'd1;
            cnt_d = SCAN_CNT - 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (row_sync_q[row_q]) begin
          // Bounce or glitch: abandon the press and move on.
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = SCAN_CNT - 32'd1;
        end else if (cnt_q == 32'd0) begin
          key_push = 1'b1;
          state_d  = ST_HELD;
          cnt_d    = DEB_CNT - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_HELD: begin
        // Any row activity on the held column restarts the release timer, so
        // other keys on this column also block scanning until released.
        if (any_row) begin
          cnt_d = DEB_CNT - 32'd1;
        end else if (cnt_q == 32'd0) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = SCAN_CNT - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = SCAN_CNT - 32'd1;
      end
    endcase
  end

  always_comb begin
    o_col = ~(4'b0001 << col_q);
  end

  // ---------------------------------------------------------------------------
  // Bus request decode
  // ---------------------------------------------------------------------------
  logic ack_q;
  logic bus_req;
  logic rd_data;
  logic wr_stat;

  // A request is taken only while ack is low, so ack lasts exactly one cycle.
  assign bus_req = i_wb_cyc & i_wb_stb & ~ack_q;
  assign rd_data = bus_req & ~i_wb_we & ~i_wb_adr;
  assign wr_stat = bus_req &  i_wb_we &  i_wb_adr & i_wb_sel[0];

  // ---------------------------------------------------------------------------
  // Key FIFO
  // ---------------------------------------------------------------------------
  logic [3:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;

  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               flush;
  logic               push_ok;
  logic               drop;
  logic [3:0]         head;
  logic [3:0]         key_code;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = rd_data & ~fifo_empty;
  assign flush      = wr_stat & i_wb_dat[2];
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push_ok    = key_push & ~flush & (~fifo_full | pop);
  assign drop       = key_push & ~flush & fifo_full & ~pop;
  assign head       = fifo_mem[rd_ptr_q];
  assign key_code   = {row_q, col_q};

  always_ff @(posedge i_wb_clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= key_code;
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A new overflow takes priority over a clear on the same edge.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (wr_stat && i_wb_dat[0]) begin
      ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt enable and interrupt output
  // ---------------------------------------------------------------------------
  logic ie;

`ifdef KEYPAD_IRQ_EN
  logic ie_q;
  logic irq_q;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_stat) ie_q <= i_wb_dat[1];
      irq_q <= ie_q & (~fifo_empty | ovf_q);
    end
  end

  assign ie    = ie_q;
  assign o_irq = irq_q;
`else
  assign ie = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and bus response
  // ---------------------------------------------------------------------------
  logic [31:0] rdt_d;
  logic [31:0] rdt_q;

  always_comb begin
    rdt_d = '0;
    if (i_wb_adr) begin
      rdt_d[8 +: FIFO_AW+1] = count_q;
      rdt_d[1]              = ie;
      rdt_d[0]              = ovf_q;
    end else if (!fifo_empty) begin
      rdt_d[8]   = 1'b1;
      rdt_d[3:0] = head;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      ack_q <= bus_req;
      if (bus_req) rdt_q <= rdt_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;

  // Only a few data and select bits are meaningful.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_wb_dat, i_wb_sel};

endmodule
